huff_enc_ctrl: RTL and testbench
================================

Name: huff_enc_ctrl

Overview:
Job sequencer in front of huff_encoder. It accepts a host symbol stream and counts the frequency of up to MAX_CHAR_COUNT distinct characters. It then resets the encoder, loads one {valid, freq, char} word per cycle onto the encoder's io_in, and captures the (char, code) word pairs from io_out into a code table. The table is readable by the host once the job completes; a watchdog catches a stalled encoder.

Parameters:
MAX_CHAR_COUNT, 3, distinct symbols per job; the encoder requires exactly this many.
FREQ_W, 3, frequency field width; counts saturate at 2^FREQ_W-1.
ENC_RST_CYCLES, 2, cycles enc_reset is held high before loading.
TIMEOUT, 64, maximum cycles from the last load word to the final captured pair.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sym_valid  in  1  host symbol valid
sym_ready  out  1  controller accepts a symbol (high in IDLE/COLLECT)
sym_data  in  8  symbol character
sym_last  in  1  last symbol of the job
enc_reset  out  1  active-high reset to huff_encoder
enc_io_in  out  12  {1'b1, freq[2:0], char[7:0]} load word; all zero when idle
enc_io_out  in  12  encoder output; bit 8 = word valid
busy  out  1  job in progress
done  out  1  table valid; held until the next job starts
err  out  1  sticky error until the next accepted symbol
err_code  out  2  0 none, 1 overflow (too many distinct), 2 underflow (too few distinct), 3 timeout
lu_char  in  8  lookup character
lu_valid  in  1  lookup request
lu_hit  out  1  registered; character present in table
lu_mask  out  MAX_CHAR_COUNT  code-length mask
lu_value  out  MAX_CHAR_COUNT  code bits

Behaviour:
- Reset values: state IDLE, enc_reset=1, enc_io_in=0, busy=0, done=0, err=0, err_code=0, lu_*=0, table and counters cleared.
- States: IDLE, COLLECT, ENC_RST, LOAD, CAPTURE, DONE, ERROR.
- IDLE -> COLLECT on the first accepted symbol (sym_valid & sym_ready). Clears done and err.
- COLLECT, per accepted symbol:
  - If the char matches an entry, that entry's freq increments, saturating at 7.
  - Otherwise a new entry is allocated in first-appearance order with freq=1.
  - A new char when all MAX_CHAR_COUNT entries are used -> ERROR, err_code=1.
  - sym_last with fewer than MAX_CHAR_COUNT entries -> ERROR, err_code=2.
  - sym_last with a full table -> ENC_RST. sym_ready drops the cycle after.
- ENC_RST: enc_reset=1 for ENC_RST_CYCLES cycles, then 0 and -> LOAD.
- LOAD: enc_io_in = {1, freq[i], char[i]} for i = 0..MAX_CHAR_COUNT-1, one word per cycle, no gaps. Then enc_io_in=0 and -> CAPTURE.
- CAPTURE:
  - Each cycle with enc_io_out[8]=1 is one word. Even-numbered words carry char in [7:0]; odd-numbered words carry mask in [5:3] and value in [2:0] for the preceding char.
  - The pair is stored into the table entry whose char matches. If no entry matches, -> ERROR, err_code=3.
  - Output words already valid during LOAD are captured too.
  - After 2*MAX_CHAR_COUNT words -> DONE.
  - The watchdog counts from entry to CAPTURE; reaching TIMEOUT -> ERROR, err_code=3.
- DONE: done=1, busy=0, enc_reset=1. An accepted symbol starts a new job: table cleared, -> COLLECT.
- ERROR: err=1, busy=0, enc_reset=1, table invalid. An accepted symbol clears err and starts a new job.
- busy=1 in COLLECT, ENC_RST, LOAD and CAPTURE.
- Lookup: registered, 1-cycle latency. Outputs update only when lu_valid=1.
  - lu_hit=1 only when done=1 and the char matches an entry.
  - On a miss, lu_mask=lu_value=0.
- Simultaneous events: sym_last on an overflowing symbol reports overflow. Lookup during a job returns a miss.
- Reset mid-job: aborts immediately to the reset values. enc_reset asserts asynchronously.

Decomposition:
- Package huff_pkg:
  - MAX_CHAR_COUNT and FREQ_W constants.
  - state_t enum.
  - err_code_t enum (ERR_NONE, ERR_OVF, ERR_UNF, ERR_TMO).
  - entry_t struct {char[7:0], freq[2:0], mask, value, used}.
- Sub-module huff_freq_table: the entry array with parallel char match, allocate, saturating increment, pair write-back and lookup port.
- The controller FSM, load counter, capture counter and watchdog live in huff_enc_ctrl.

Test Plan:
- Stream a,a,n,a,m,n,a,m (last on the final m).
  - Load words 0xC61, 0xA6E, 0xA6D on consecutive cycles.
  - After the encoder replies, done=1 with a = mask 001 / value 001, n = 011/000, m = 011/001.
- Stream of 9 'a' + n + m.
  - a freq saturates at 7; first load word is 0xF61.
- Stream a,n,m,x.
  - ERROR with err_code=1 on x; enc_io_in stays 0; no encoder load.
- Stream a,n (last).
  - err_code=2; a following new stream a,n,m runs cleanly and clears err.
- Stub encoder never asserts bit 8.
  - err_code=3 exactly TIMEOUT cycles after CAPTURE entry.
- Assert reset_n low during LOAD.
  - All outputs return to reset values the same cycle; the next job loads correctly.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants, state/error encodings and the frequency-table entry layout
// for the Huffman encoder job sequencer.
package huff_pkg;

    localparam int unsigned MAX_CHAR_COUNT = 3;
    localparam int unsigned FREQ_W         = 3;
    localparam int unsigned CNT_W          = $clog2(MAX_CHAR_COUNT + 1);
    localparam int unsigned IDX_W          = $clog2(MAX_CHAR_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ENC_RST,
        S_LOAD,
        S_CAPTURE,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    typedef struct packed {
        logic [7:0]                char;
        logic [FREQ_W-1:0]         freq;
        logic [MAX_CHAR_COUNT-1:0] mask;
        logic [MAX_CHAR_COUNT-1:0] value;
        logic                      used;
    } entry_t;

endpackage

// File: rtl/huff_freq_table.sv
// Symbol frequency / code table: parallel char match, first-appearance allocation,
// saturating counts, code write-back and a registered host lookup port.
module huff_freq_table
    import huff_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_sym_en,
    input  logic [7:0]                i_sym_char,
    output logic                      o_sym_hit,
    output logic                      o_full,
    output logic [CNT_W-1:0]          o_count,
    input  logic [IDX_W-1:0]          i_rd_idx,
    output logic [7:0]                o_rd_char,
    output logic [FREQ_W-1:0]         o_rd_freq,
    input  logic                      i_wr_en,
    input  logic [7:0]                i_wr_char,
    input  logic [MAX_CHAR_COUNT-1:0] i_wr_mask,
    input  logic [MAX_CHAR_COUNT-1:0] i_wr_value,
    output logic                      o_wr_hit,
    input  logic                      i_lu_valid,
    input  logic                      i_lu_allow,
    input  logic [7:0]                i_lu_char,
    output logic                      o_lu_hit,
    output logic [MAX_CHAR_COUNT-1:0] o_lu_mask,
    output logic [MAX_CHAR_COUNT-1:0] o_lu_value
);

    entry_t                    r_tab [MAX_CHAR_COUNT];
    logic [CNT_W-1:0]          r_count;
    logic                      r_lu_hit;
    logic [MAX_CHAR_COUNT-1:0] r_lu_mask;
    logic [MAX_CHAR_COUNT-1:0] r_lu_value;

    logic [MAX_CHAR_COUNT-1:0] w_sym_match;
    logic [MAX_CHAR_COUNT-1:0] w_wr_match;
    logic [MAX_CHAR_COUNT-1:0] w_lu_match;
    logic [MAX_CHAR_COUNT-1:0] w_lu_mask;
    logic [MAX_CHAR_COUNT-1:0] w_lu_value;
    entry_t                    w_new;

    always_comb begin
        w_sym_match = '0;
        w_wr_match  = '0;
        w_lu_match  = '0;
        w_lu_mask   = '0;
        w_lu_value  = '0;
        o_rd_char   = '0;
        o_rd_freq   = '0;
        for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++) begin
            w_sym_match[i] = r_tab[i].used && (r_tab[i].char == i_sym_char);
            w_wr_match[i]  = r_tab[i].used && (r_tab[i].char == i_wr_char);
            w_lu_match[i]  = r_tab[i].used && (r_tab[i].char == i_lu_char);
            if (w_lu_match[i]) begin
                w_lu_mask  = r_tab[i].mask;
                w_lu_value = r_tab[i].value;
            end
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_char = r_tab[i].char;
                o_rd_freq = r_tab[i].freq;
            end
        end
    end

    assign w_new     = '{char: i_sym_char, freq: FREQ_W'(1), mask: '0, value: '0, used: 1'b1};
    assign o_sym_hit = |w_sym_match;
    assign o_wr_hit  = |w_wr_match;
    assign o_full    = (r_count == CNT_W'(MAX_CHAR_COUNT));
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++) r_tab[i] <= '0;
            r_count    <= '0;
            r_lu_hit   <= 1'b0;
            r_lu_mask  <= '0;
            r_lu_value <= '0;
        end else begin
            if (i_clear) begin
                // A new job's first symbol lands directly in slot 0 of the wiped table.
                for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++) r_tab[i] <= '0;
                if (i_sym_en) begin
                    r_tab[0] <= w_new;
                    r_count  <= CNT_W'(1);
                end else begin
                    r_count  <= '0;
                end
            end else begin
                if (i_sym_en) begin
                    if (o_sym_hit) begin
                        for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++)
                            if (w_sym_match[i] && (r_tab[i].freq != '1))
                                r_tab[i].freq <= r_tab[i].freq + FREQ_W'(1);
                    end else if (!o_full) begin
                        for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++)
                            if (r_count == CNT_W'(i)) r_tab[i] <= w_new;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                if (i_wr_en) begin
                    for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++)
                        if (w_wr_match[i]) begin
                            r_tab[i].mask  <= i_wr_mask;
                            r_tab[i].value <= i_wr_value;
                        end
                end
            end
            if (i_lu_valid) begin
                r_lu_hit   <= i_lu_allow && (|w_lu_match);
                r_lu_mask  <= (i_lu_allow && (|w_lu_match)) ? w_lu_mask  : '0;
                r_lu_value <= (i_lu_allow && (|w_lu_match)) ? w_lu_value : '0;
            end
        end
    end

    assign o_lu_hit   = r_lu_hit;
    assign o_lu_mask  = r_lu_mask;
    assign o_lu_value = r_lu_value;

endmodule

// File: rtl/huff_enc_ctrl.sv
// Job sequencer for huff_encoder: collects symbol frequencies, resets and loads the
// encoder, captures the (char, code) pairs and guards the reply with a watchdog.
module huff_enc_ctrl
    import huff_pkg::*;
#(
    parameter int unsigned ENC_RST_CYCLES = 2,
    parameter int unsigned TIMEOUT        = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sym_valid,
    output logic                      sym_ready,
    input  logic [7:0]                sym_data,
    input  logic                      sym_last,
    output logic                      enc_reset,
    output logic [11:0]               enc_io_in,
    input  logic [11:0]               enc_io_out,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    input  logic [7:0]                lu_char,
    input  logic                      lu_valid,
    output logic                      lu_hit,
    output logic [MAX_CHAR_COUNT-1:0] lu_mask,
    output logic [MAX_CHAR_COUNT-1:0] lu_value
);

    localparam int unsigned WORDS = 2 * MAX_CHAR_COUNT;
    localparam int unsigned WC_W  = $clog2(WORDS + 1);
    localparam int unsigned RST_W = $clog2(ENC_RST_CYCLES) + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

    state_t           r_state, w_state_nxt;
    err_code_t        r_err_code, w_err_nxt;
    logic [RST_W-1:0] r_rst_cnt;
    logic [IDX_W-1:0] r_ld_idx;
    logic [WD_W-1:0]  r_wd;
    logic [WC_W-1:0]  r_wcnt, w_wcnt_nxt;
    logic [7:0]       r_pend_char;

    logic              w_accept, w_clear, w_sym_en, w_sym_hit, w_full;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_rd_char;
    logic [FREQ_W-1:0] w_rd_freq;
    logic              w_capture, w_wr_en, w_wr_hit, w_pair_err;
    logic              w_unused;

    assign w_unused   = ^enc_io_out[11:9];
    assign w_accept   = sym_valid && sym_ready;
    assign w_capture  = ((r_state == S_LOAD) || (r_state == S_CAPTURE)) && enc_io_out[8]
                        && (r_wcnt != WC_W'(WORDS));
    assign w_wr_en    = w_capture && r_wcnt[0];
    assign w_pair_err = w_wr_en && !w_wr_hit;
    assign w_wcnt_nxt = r_wcnt + (w_capture ? WC_W'(1) : WC_W'(0));

    huff_freq_table u_table (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_clear    (w_clear),
        .i_sym_en   (w_sym_en),
        .i_sym_char (sym_data),
        .o_sym_hit  (w_sym_hit),
        .o_full     (w_full),
        .o_count    (w_count),
        .i_rd_idx   (r_ld_idx),
        .o_rd_char  (w_rd_char),
        .o_rd_freq  (w_rd_freq),
        .i_wr_en    (w_wr_en),
        .i_wr_char  (r_pend_char),
        .i_wr_mask  (enc_io_out[5:3]),
        .i_wr_value (enc_io_out[2:0]),
        .o_wr_hit   (w_wr_hit),
        .i_lu_valid (lu_valid),
        .i_lu_allow (r_state == S_DONE),
        .i_lu_char  (lu_char),
        .o_lu_hit   (lu_hit),
        .o_lu_mask  (lu_mask),
        .o_lu_value (lu_value)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err_code;
        w_clear     = 1'b0;
        w_sym_en    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept) begin
                    w_clear     = 1'b1;
                    w_sym_en    = 1'b1;
                    w_err_nxt   = ERR_NONE;
                    w_state_nxt = S_COLLECT;
                    if (sym_last) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = ERR_UNF;
                    end
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_sym_en = 1'b1;
                    // Overflow outranks sym_last on the same symbol.
                    if (!w_sym_hit && w_full) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = ERR_OVF;
                    end else if (sym_last) begin
                        if (w_sym_hit ? w_full : (w_count == CNT_W'(MAX_CHAR_COUNT - 1))) begin
                            w_state_nxt = S_ENC_RST;
                        end else begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = ERR_UNF;
                        end
                    end
                end
            end
            S_ENC_RST: begin
                if (r_rst_cnt == RST_W'(ENC_RST_CYCLES - 1)) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_pair_err) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = ERR_TMO;
                end else if (r_ld_idx == IDX_W'(MAX_CHAR_COUNT - 1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_pair_err) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = ERR_TMO;
                end else if (w_wcnt_nxt == WC_W'(WORDS)) begin
                    w_state_nxt = S_DONE;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = ERR_TMO;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_err_code  <= ERR_NONE;
            r_rst_cnt   <= '0;
            r_ld_idx    <= '0;
            r_wd        <= '0;
            r_wcnt      <= '0;
            r_pend_char <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_err_code <= w_err_nxt;
            r_rst_cnt  <= (r_state == S_ENC_RST) ? r_rst_cnt + RST_W'(1) : '0;
            r_ld_idx   <= (r_state == S_LOAD)    ? r_ld_idx + IDX_W'(1)  : '0;
            r_wd       <= (r_state == S_CAPTURE) ? r_wd + WD_W'(1)       : '0;
            r_wcnt     <= ((r_state == S_LOAD) || (r_state == S_CAPTURE)) ? w_wcnt_nxt : '0;
            if (w_capture && !r_wcnt[0]) r_pend_char <= enc_io_out[7:0];
        end
    end

    assign sym_ready = (r_state == S_IDLE) || (r_state == S_COLLECT)
                       || (r_state == S_DONE) || (r_state == S_ERROR);
    assign busy      = (r_state == S_COLLECT) || (r_state == S_ENC_RST)
                       || (r_state == S_LOAD) || (r_state == S_CAPTURE);
    assign enc_reset = !((r_state == S_LOAD) || (r_state == S_CAPTURE));
    assign enc_io_in = (r_state == S_LOAD) ? {1'b1, w_rd_freq, w_rd_char} : '0;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_huff_enc_ctrl.sv
// Directed bench for huff_enc_ctrl with a scripted stand-in for the encoder replies.
module tb_huff_enc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [7:0]  sym_data = '0;
    logic        sym_last = 1'b0;
    logic        enc_reset;
    logic [11:0] enc_io_in;
    logic [11:0] enc_io_out = '0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [7:0]  lu_char = '0;
    logic        lu_valid = 1'b0;
    logic        lu_hit;
    logic [2:0]  lu_mask, lu_value;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    huff_enc_ctrl #(.ENC_RST_CYCLES(2), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .enc_reset  (enc_reset),
        .enc_io_in  (enc_io_in),
        .enc_io_out (enc_io_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .lu_char    (lu_char),
        .lu_valid   (lu_valid),
        .lu_hit     (lu_hit),
        .lu_mask    (lu_mask),
        .lu_value   (lu_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sym_valid = 1'b1;
            sym_data  = s[i];
            sym_last  = (i == s.len() - 1);
            tick();
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        sym_data  = '0;
    endtask

    // Called right after sym_last is accepted; returns in the first LOAD cycle.
    task automatic enc_rst_phase(input string tag);
        n_checks++;
        if (sym_ready !== 1'b0 || busy !== 1'b1 || enc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_encrst0: ready/busy/enc_reset=%b%b%b expected 011", tag, sym_ready, busy, enc_reset);
        end
        tick();
        n_checks++;
        if (enc_reset !== 1'b1 || enc_io_in !== 12'h000) begin
            n_fail++;
            $display("FAIL %s_encrst1: enc_reset=%b io_in=%h expected 1/000", tag, enc_reset, enc_io_in);
        end
        tick();
    endtask

    task automatic check_load(input string tag, input logic [11:0] w0, w1, w2);
        logic [2:0][11:0] w;
        w = {w2, w1, w0};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (enc_io_in !== w[i] || enc_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_load%0d: io_in=%h enc_reset=%b expected %h/0", tag, i, enc_io_in, enc_reset, w[i]);
            end
            tick();
        end
        n_checks++;
        if (enc_io_in !== 12'h000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_capture_entry: io_in=%h busy=%b expected 000/1", tag, enc_io_in, busy);
        end
    endtask

    task automatic reply(input logic [2:0][7:0] c, input logic [2:0][5:0] mv);
        for (int i = 0; i < 3; i++) begin
            enc_io_out = {3'b000, 1'b1, c[i]};
            tick();
            enc_io_out = {3'b000, 1'b1, 2'b00, mv[i]};
            tick();
        end
        enc_io_out = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (enc_reset !== 1'b1 || enc_io_in !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_enc: enc_reset=%b io_in=%h expected 1/000", enc_reset, enc_io_in);
        end
        n_checks++;
        if ({busy, done, err, err_code} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_status: busy/done/err/code=%b expected 00000", {busy, done, err, err_code});
        end
        n_checks++;
        if ({lu_hit, lu_mask, lu_value} !== 7'b0 || sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_lu: lu=%b ready=%b expected 0000000/1", {lu_hit, lu_mask, lu_value}, sym_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, err} !== 3'b000 || enc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: busy/done/err=%b enc_reset=%b expected 000/1", {busy, done, err}, enc_reset);
        end
    endtask

    task automatic test_basic();
        send_stream("aanamnam");
        enc_rst_phase("basic");
        check_load("basic", 12'hC61, 12'hA6E, 12'hA6D);
        reply({8'h6D, 8'h61, 8'h6E}, {6'b011001, 6'b001001, 6'b011000});
        n_checks++;
        if ({done, busy, err, enc_reset} !== 4'b1001) begin
            n_fail++;
            $display("FAIL basic_done: done/busy/err/enc_reset=%b expected 1001", {done, busy, err, enc_reset});
        end
    endtask

    task automatic test_lookup();
        logic [3:0][7:0] c;
        logic [3:0][6:0] e;
        c = {8'h7A, 8'h6D, 8'h6E, 8'h61};
        e = {7'b0_000_000, 7'b1_011_001, 7'b1_011_000, 7'b1_001_001};
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1;
            lu_char  = c[i];
            tick();
            n_checks++;
            if ({lu_hit, lu_mask, lu_value} !== e[i]) begin
                n_fail++;
                $display("FAIL lookup_%0d: hit/mask/value=%b expected %b", i, {lu_hit, lu_mask, lu_value}, e[i]);
            end
        end
        lu_valid = 1'b0;
        lu_char  = 8'h61;
        tick();
        n_checks++;
        if ({lu_hit, lu_mask, lu_value} !== 7'b0) begin
            n_fail++;
            $display("FAIL lookup_hold: hit/mask/value=%b expected 0000000", {lu_hit, lu_mask, lu_value});
        end
    endtask

    task automatic test_saturate();
        send_stream("aaaaaaaaanm");
        enc_rst_phase("sat");
        n_checks++;
        if (enc_io_in !== 12'hF61) begin
            n_fail++;
            $display("FAIL sat_word0: io_in=%h expected F61", enc_io_in);
        end
        // Encoder replies begin while words are still being loaded.
        reply({8'h6D, 8'h6E, 8'h61}, {6'b011011, 6'b011010, 6'b001000});
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_done_early_words: done=%b expected 1", done);
        end
        lu_valid = 1'b1;
        lu_char  = 8'h6E;
        tick();
        lu_valid = 1'b0;
        n_checks++;
        if ({lu_hit, lu_mask, lu_value} !== 7'b1_011_010) begin
            n_fail++;
            $display("FAIL sat_lookup_n: hit/mask/value=%b expected 1011010", {lu_hit, lu_mask, lu_value});
        end
    endtask

    task automatic test_overflow();
        send_stream("anmx");
        n_checks++;
        if ({err, err_code, busy} !== 4'b1010 || enc_io_in !== 12'h000) begin
            n_fail++;
            $display("FAIL ovf_err: err/code/busy=%b io_in=%h expected 1010/000", {err, err_code, busy}, enc_io_in);
        end
        lu_valid = 1'b1;
        lu_char  = 8'h61;
        for (int i = 0; i < 4; i++) tick();
        lu_valid = 1'b0;
        n_checks++;
        if (enc_io_in !== 12'h000 || enc_reset !== 1'b1 || lu_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_quiet: io_in=%h enc_reset=%b lu_hit=%b expected 000/1/0", enc_io_in, enc_reset, lu_hit);
        end
    endtask

    task automatic test_underflow();
        send_stream("an");
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL unf_err: err=%b code=%0d expected 1/2", err, err_code);
        end
        sym_valid = 1'b1;
        sym_data  = 8'h61;
        lu_valid  = 1'b0;
        tick();
        sym_valid = 1'b0;
        lu_valid  = 1'b1;
        lu_char   = 8'h61;
        n_checks++;
        if ({err, err_code, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL unf_clear: err/code/busy=%b expected 0001", {err, err_code, busy});
        end
        tick();
        lu_valid = 1'b0;
        n_checks++;
        if (lu_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_lookup_midjob: lu_hit=%b expected 0", lu_hit);
        end
        send_stream("nm");
        enc_rst_phase("unf2");
        check_load("unf2", 12'h961, 12'h96E, 12'h96D);
        reply({8'h61, 8'h6D, 8'h6E}, {6'b011000, 6'b011001, 6'b001001});
        n_checks++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL unf2_done: done/err=%b expected 10", {done, err});
        end
    endtask

    task automatic test_timeout();
        send_stream("anm");
        enc_rst_phase("tmo");
        check_load("tmo", 12'h961, 12'h96E, 12'h96D);
        for (int i = 0; i < 63; i++) tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: err=%b busy=%b expected 0/1 after 63 cycles", err, busy);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || enc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_fire: err=%b code=%0d enc_reset=%b expected 1/3/1", err, err_code, enc_reset);
        end
    endtask

    task automatic test_reset_midjob();
        send_stream("anm");
        enc_rst_phase("rst");
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (enc_reset !== 1'b1 || enc_io_in !== 12'h000 || {busy, done, err, err_code} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async: enc_reset=%b io_in=%h status=%b expected 1/000/00000",
                     enc_reset, enc_io_in, {busy, done, err, err_code});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        send_stream("aanm");
        enc_rst_phase("rst2");
        check_load("rst2", 12'hA61, 12'h96E, 12'h96D);
        reply({8'h6E, 8'h6D, 8'h61}, {6'b011001, 6'b011000, 6'b001001});
        n_checks++;
        if ({done, err, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst2_done: done/err/busy=%b expected 100", {done, err, busy});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lookup();
        test_saturate();
        test_overflow();
        test_underflow();
        test_timeout();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
